synaptic_processing_unit_n: RTL and testbench
=============================================

Name: synaptic_processing_unit_n

Overview:
Parametrised successor of the two-destination synaptic processing unit. It pops spike events (source tags) from the spike FIFO, then walks N_DST destinations for each one. Per destination it reads the synaptic weight and current i_next, adds them, and writes the sum back as i_next. It sits between the spike FIFO and the weight/i_next memories, ahead of the Izhikevich neuron update units.

Parameters:
DATA_W, 17, width of weight and i_next (signed two's-complement fixed point)
SRC_W, 4, width of source neuron tag
N_DST, 4, destinations per source event (>=1)
DST_W, 2, width of destination tag (>= clog2(N_DST), minimum 1)

Ports:
clk  input  1  clock, rising edge
asyn_reset  input  1  asynchronous, active-low reset
fifo_empty  input  1  spike FIFO empty flag
src_tag_in  input  SRC_W  FIFO head source tag (fall-through, valid while !fifo_empty)
req_deq  output  1  one-cycle FIFO dequeue strobe
rd_req  output  1  read request to weight/i_next memories
rd_src  output  SRC_W  source tag for weight read
rd_dst  output  DST_W  destination tag for weight and i_next read
weight_in  input  DATA_W  weight; valid the cycle after rd_req
i_next_in  input  DATA_W  i_next; valid the cycle after rd_req
req_write_i_next  output  1  i_next write request
wr_stall  input  1  memory cannot accept write this cycle
i_next_out  output  DATA_W  i_next write data
dst_tag_out  output  DST_W  i_next write address
src_tag_out  output  SRC_W  source tag of event in progress
busy  output  1  high in every state except IDLE
state  output  3  current FSM state (debug)

Behaviour:
- Reset (asyn_reset=0, asynchronous): state=IDLE. All outputs 0. Internal src/dst/sum registers 0.
- Reset mid-event: the event in progress is abandoned. No further write is issued. Any write not yet accepted is dropped.
- State encoding: IDLE=0, DEQ=1, FETCH=2, ADD=3, WRITE=4.
- IDLE: if !fifo_empty, go to DEQ; else stay.
- DEQ: req_deq=1 for exactly this cycle. Latch src_tag_in into src_tag_out. Clear dst counter to 0. Go to FETCH.
- FETCH: rd_req=1, rd_src=src_tag_out, rd_dst=dst counter. Go to ADD.
- ADD: capture weight_in + i_next_in into the sum register. Go to WRITE.
- WRITE: req_write_i_next=1, i_next_out=sum, dst_tag_out=dst counter.
  - If wr_stall=1: stay in WRITE with all outputs held stable.
  - Else if dst counter != N_DST-1: increment the counter and go to FETCH.
  - Else if !fifo_empty: go to DEQ (back-to-back events, no IDLE bubble).
  - Else: go to IDLE.
- rd_req, req_deq and req_write_i_next are mutually exclusive and are never asserted outside their own states.
- Latency with no stall:
  - 3 cycles per destination.
  - 1+3*N_DST cycles per event.
  - First req_deq occurs 1 cycle after fifo_empty falls while in IDLE.
- Read-after-write: a write to destination d completes before the next FETCH is issued. The memory must return the updated i_next on any later read of d.
- fifo_empty is sampled only in IDLE and at the final WRITE. Toggling it elsewhere has no effect.
- Arithmetic: signed DATA_W+1-bit internal sum, reduced to DATA_W per the Optional Feature.
- N_DST=1: the counter stays at 0 and every WRITE is the final WRITE.

Optional Feature:
SPU_SAT_EN:
- Defined: saturating add. Positive overflow clamps to 2^(DATA_W-1)-1; negative overflow clamps to -2^(DATA_W-1). Adds one sticky output, sat_flag (1 bit). It sets on any clamp and clears only on reset.
- Undefined: sum truncated to DATA_W bits (modulo wrap). No sat_flag port.

Test Plan:
1. Reset, then fifo_empty=1 for 3 cycles -> state=0, busy=0, no strobes asserted.
2. src_tag_in=1, one event, memory returns weight=0x00800 and i_next=0x00100 for all dst -> req_deq pulses once. Four writes of 0x00900 to dst 0,1,2,3 at cycles 4,7,10,13 after DEQ. Then IDLE.
3. Two events queued (FIFO holds 2, 3) -> final WRITE of event 2 goes straight to DEQ. src_tag_out=3 and no IDLE cycle occurs between events.
4. wr_stall=1 for 2 cycles during the dst=1 write -> WRITE is held 3 cycles with i_next_out and dst_tag_out stable. Only one write is accepted.
5. With SPU_SAT_EN, weight=0x0F000 and i_next=0x0F000 -> i_next_out=0x0FFFF and sat_flag=1. weight=0x10000 and i_next=0x1F000 -> i_next_out=0x10000. Without the macro, the first case gives 0x1E000.
6. asyn_reset pulsed low during ADD of dst=2 -> outputs go to 0 immediately and no write occurs for dst=2. After release, a new event processes normally starting at dst=0.

Source files
------------

// File: rtl/synaptic_processing_unit_n_if.sv
// ---------------------------------------------------------------------------
// synaptic_processing_unit_n_if
// Bundles the spike-FIFO, memory-read, memory-write and status signals of the
// synaptic processing unit.
//   master : the processing unit's view (drives strobes, addresses, data out)
//   slave  : the environment's view (FIFO, weight/i_next memories)
// Optional macro SPU_SAT_EN adds the sticky sat_flag status signal.
// Parameters: DATA_W (weight/i_next width), SRC_W (source tag width),
//             DST_W (destination tag width).
// ---------------------------------------------------------------------------
interface synaptic_processing_unit_n_if #(
    parameter int DATA_W = 17,
    parameter int SRC_W  = 4,
    parameter int DST_W  = 2
);
    logic              fifo_empty;
    logic [SRC_W-1:0]  src_tag_in;
    logic              req_deq;
    logic              rd_req;
    logic [SRC_W-1:0]  rd_src;
    logic [DST_W-1:0]  rd_dst;
    logic [DATA_W-1:0] weight_in;
    logic [DATA_W-1:0] i_next_in;
    logic              req_write_i_next;
    logic              wr_stall;
    logic [DATA_W-1:0] i_next_out;
    logic [DST_W-1:0]  dst_tag_out;
    logic [SRC_W-1:0]  src_tag_out;
    logic              busy;
    logic [2:0]        state;
`ifdef SPU_SAT_EN
    logic              sat_flag;
`endif

    modport master (
        input  fifo_empty, src_tag_in, weight_in, i_next_in, wr_stall,
        output req_deq, rd_req, rd_src, rd_dst, req_write_i_next,
        output i_next_out, dst_tag_out, src_tag_out, busy, state
`ifdef SPU_SAT_EN
        , output sat_flag
`endif
    );

    modport slave (
        output fifo_empty, src_tag_in, weight_in, i_next_in, wr_stall,
        input  req_deq, rd_req, rd_src, rd_dst, req_write_i_next,
        input  i_next_out, dst_tag_out, src_tag_out, busy, state
`ifdef SPU_SAT_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/synaptic_processing_unit_n.sv
// ---------------------------------------------------------------------------
// synaptic_processing_unit_n
// Pops spike events (source tags) from the spike FIFO and, for each one,
// walks N_DST destinations: read weight and i_next, add them, write the sum
// back as i_next. Sits between the spike FIFO and the weight/i_next memories.
//
// Ports:
//   clk         rising-edge clock
//   asyn_reset  asynchronous active-low reset
//   bus         synaptic_processing_unit_n_if.master:
//                 FIFO side    fifo_empty, src_tag_in, req_deq
//                 read side    rd_req, rd_src, rd_dst, weight_in, i_next_in
//                 write side   req_write_i_next, wr_stall, i_next_out,
//                              dst_tag_out
//                 status       src_tag_out, busy, state[, sat_flag]
//
// Optional macro SPU_SAT_EN: saturating add plus sticky sat_flag output;
// when undefined the sum wraps modulo 2^DATA_W and sat_flag does not exist.
//
// All outputs are registered; strobes are computed from the next state so
// they are high exactly while the FSM sits in the matching state.
// ---------------------------------------------------------------------------
module synaptic_processing_unit_n #(
    parameter int DATA_W = 17,
    parameter int SRC_W  = 4,
    parameter int N_DST  = 4,
    parameter int DST_W  = 2
) (
    input  logic clk,
    input  logic asyn_reset,
    synaptic_processing_unit_n_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEQ   = 3'd1,
        ST_FETCH = 3'd2,
        ST_ADD   = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [DST_W-1:0] DST_LAST = DST_W'(N_DST - 1);
    localparam logic [DST_W-1:0] DST_ONE  = DST_W'(1);

    // Sign-extend both operands so the DATA_W+1 result never overflows.
    function automatic logic [DATA_W:0] wide_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

`ifdef SPU_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // The two top bits of the wide sum disagree exactly when it is out of range.
    function automatic logic sum_ovf(input logic [DATA_W:0] s);
        return s[DATA_W] ^ s[DATA_W-1];
    endfunction

    // Clamp toward the sign of the true (wide) result.
    function automatic logic [DATA_W-1:0] reduce_sum(input logic [DATA_W:0] s);
        if (sum_ovf(s)) begin
            return s[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction
`else
    // Modulo wrap: keep the low DATA_W bits.
    function automatic logic [DATA_W-1:0] reduce_sum(input logic [DATA_W:0] s);
        return s[DATA_W-1:0];
    endfunction
`endif

    state_t            state_r;
    state_t            state_n;
    logic [SRC_W-1:0]  src_r;
    logic [DST_W-1:0]  dst_r;
    logic [DATA_W-1:0] sum_r;
    logic              req_deq_r;
    logic              rd_req_r;
    logic              req_write_r;
    logic              busy_r;
`ifdef SPU_SAT_EN
    logic              sat_r;
`endif

    // Next-state logic; fifo_empty only matters in IDLE and at the final WRITE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    state_n = ST_DEQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DEQ:   state_n = ST_FETCH;
            ST_FETCH: state_n = ST_ADD;
            ST_ADD:   state_n = ST_WRITE;
            ST_WRITE: begin
                if (bus.wr_stall) begin
                    state_n = ST_WRITE;
                end else if (dst_r != DST_LAST) begin
                    state_n = ST_FETCH;
                end else if (!bus.fifo_empty) begin
                    state_n = ST_DEQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, datapath registers and registered strobes.
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_r     <= ST_IDLE;
            src_r       <= {SRC_W{1'b0}};
            dst_r       <= {DST_W{1'b0}};
            sum_r       <= {DATA_W{1'b0}};
            req_deq_r   <= 1'b0;
            rd_req_r    <= 1'b0;
            req_write_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SPU_SAT_EN
            sat_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            req_deq_r   <= (state_n == ST_DEQ);
            rd_req_r    <= (state_n == ST_FETCH);
            req_write_r <= (state_n == ST_WRITE);
            busy_r      <= (state_n != ST_IDLE);
            case (state_r)
                ST_DEQ: begin
                    src_r <= bus.src_tag_in;
                    dst_r <= {DST_W{1'b0}};
                end
                ST_ADD: begin
                    sum_r <= reduce_sum(wide_add(bus.weight_in, bus.i_next_in));
`ifdef SPU_SAT_EN
                    if (sum_ovf(wide_add(bus.weight_in, bus.i_next_in))) begin
                        sat_r <= 1'b1;
                    end else begin
                        sat_r <= sat_r;
                    end
`endif
                end
                ST_WRITE: begin
                    // Counter only advances once the write is accepted and
                    // more destinations remain; with N_DST=1 it stays at 0.
                    if (!bus.wr_stall && (dst_r != DST_LAST)) begin
                        dst_r <= dst_r + DST_ONE;
                    end else begin
                        dst_r <= dst_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_deq          = req_deq_r;
    assign bus.rd_req           = rd_req_r;
    assign bus.rd_src           = src_r;
    assign bus.rd_dst           = dst_r;
    assign bus.req_write_i_next = req_write_r;
    assign bus.i_next_out       = sum_r;
    assign bus.dst_tag_out      = dst_r;
    assign bus.src_tag_out      = src_r;
    assign bus.busy             = busy_r;
    assign bus.state            = state_r;
`ifdef SPU_SAT_EN
    assign bus.sat_flag         = sat_r;
`endif

endmodule

// File: tb/tb_synaptic_processing_unit_n.sv
// ---------------------------------------------------------------------------
// tb_synaptic_processing_unit_n
// Bench models the spike FIFO and the weight/i_next memories. Each pushed
// event queues its expected writes (computed from a shadow copy of i_next);
// a monitor pops and compares every accepted write.
// ---------------------------------------------------------------------------
module tb_synaptic_processing_unit_n;
    localparam int DATA_W = 17;
    localparam int SRC_W  = 4;
    localparam int N_DST  = 4;
    localparam int DST_W  = 2;

    typedef struct packed {
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic asyn_reset;

    synaptic_processing_unit_n_if #(.DATA_W(DATA_W), .SRC_W(SRC_W), .DST_W(DST_W)) bus ();

    synaptic_processing_unit_n #(
        .DATA_W(DATA_W), .SRC_W(SRC_W), .N_DST(N_DST), .DST_W(DST_W)
    ) dut (
        .clk(clk),
        .asyn_reset(asyn_reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int fall_cyc;
    int idle_seen;
    int excl_viol;
    int wr_count;

    wr_t               exp_q[$];
    logic [SRC_W-1:0]  fifo_q[$];
    int                wr_cyc_q[$];
    int                deq_cyc_q[$];
    int                deq_idle_q[$];
    logic [DATA_W-1:0] wr_val_q[$];
    logic [DST_W-1:0]  wr_dst_q[$];

    logic [DATA_W-1:0] wmem [16][N_DST];
    logic [DATA_W-1:0] inext_mem [N_DST];
    logic [DATA_W-1:0] shadow [N_DST];

    logic              rd_pend, wr_pend, deq_pend, prev_empty;
    logic [SRC_W-1:0]  rd_src_p;
    logic [DST_W-1:0]  rd_dst_p, wr_dst_p;
    logic [DATA_W-1:0] wr_data_p;

    // Reference add: exact integer sum, then clamp or wrap to DATA_W bits.
    function automatic logic [DATA_W-1:0] model_add(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        int sa;
        int sb;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb;
`ifdef SPU_SAT_EN
        if (s > 65535)  return 17'h0FFFF;
        if (s < -65536) return 17'h10000;
`endif
        return s[DATA_W-1:0];
    endfunction

    task automatic push_event(input logic [SRC_W-1:0] src);
        wr_t e;
        fifo_q.push_back(src);
        for (int d = 0; d < N_DST; d++) begin
            shadow[d] = model_add(wmem[src][d], shadow[d]);
            e.dst  = DST_W'(d);
            e.data = shadow[d];
            exp_q.push_back(e);
        end
    endtask

    task automatic set_inext(input logic [DATA_W-1:0] v);
        for (int d = 0; d < N_DST; d++) begin
            inext_mem[d] = v;
            shadow[d]    = v;
        end
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete();
        deq_cyc_q.delete();
        deq_idle_q.delete();
        wr_val_q.delete();
        wr_dst_q.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.state === 3'd0 && fifo_q.size() == 0 && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout: state=%0d pending_writes=%0d required idle with none pending",
                     name, bus.state, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({bus.state, bus.busy, bus.req_deq, bus.rd_req, bus.req_write_i_next,
             bus.i_next_out, bus.dst_tag_out, bus.src_tag_out, bus.rd_src, bus.rd_dst} !== '0) begin
            errors++;
            $display("FAIL %s: state=%0d busy=%b deq=%b rd=%b wr=%b out=%h dst=%0d src=%0d rd_src=%0d rd_dst=%0d required all 0",
                     name, bus.state, bus.busy, bus.req_deq, bus.rd_req, bus.req_write_i_next,
                     bus.i_next_out, bus.dst_tag_out, bus.src_tag_out, bus.rd_src, bus.rd_dst);
        end
`ifdef SPU_SAT_EN
        checks++;
        if (bus.sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s sat_flag: got %b required 0", name, bus.sat_flag);
        end
`endif
    endtask

    task automatic test_reset();
        asyn_reset = 1'b0;
        #1;
        check_outputs_zero("reset_in");
        repeat (2) @(negedge clk);
        asyn_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.req_deq !== 1'b0 ||
                bus.rd_req !== 1'b0 || bus.req_write_i_next !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: state=%0d busy=%b deq=%b rd=%b wr=%b required 0 0 0 0 0",
                         bus.state, bus.busy, bus.req_deq, bus.rd_req, bus.req_write_i_next);
            end
        end
    endtask

    task automatic test_single_event();
        clear_logs();
        for (int d = 0; d < N_DST; d++) wmem[1][d] = 17'h00800;
        set_inext(17'h00100);
        push_event(4'd1);
        wait_done("single", 60);
        checks++;
        if (deq_cyc_q.size() != 1 || deq_cyc_q[0] != fall_cyc + 1) begin
            errors++;
            $display("FAIL single_deq: deq count=%0d first deq offset=%0d required 1 and 1",
                     deq_cyc_q.size(), (deq_cyc_q.size() > 0) ? deq_cyc_q[0] - fall_cyc : -1);
        end
        checks++;
        if (wr_cyc_q.size() != 4) begin
            errors++;
            $display("FAIL single_wr_count: got %0d required 4", wr_cyc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                // DEQ is cycle 1, so offsets 3,6,9,12 are cycles 4,7,10,13.
                if (wr_cyc_q[i] - deq_cyc_q[0] != 3 * (i + 1) || wr_val_q[i] !== 17'h00900 ||
                    wr_dst_q[i] !== DST_W'(i)) begin
                    errors++;
                    $display("FAIL single_wr%0d: offset=%0d data=%h dst=%0d required %0d 00900 %0d",
                             i, wr_cyc_q[i] - deq_cyc_q[0], wr_val_q[i], wr_dst_q[i], 3 * (i + 1), i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_logs();
        for (int s = 2; s < 4; s++)
            for (int d = 0; d < N_DST; d++)
                wmem[s][d] = DATA_W'(s * 256 + d * 37) - 17'h00300;
        set_inext(17'h1FF00);
        push_event(4'd2);
        push_event(4'd3);
        n = 0;
        while (deq_cyc_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (bus.state !== 3'd2 || bus.src_tag_out !== 4'd3 || bus.rd_src !== 4'd3) begin
            errors++;
            $display("FAIL b2b_src: state=%0d src_tag_out=%0d rd_src=%0d required 2 3 3",
                     bus.state, bus.src_tag_out, bus.rd_src);
        end
        wait_done("b2b", 60);
        checks++;
        if (deq_cyc_q.size() != 2 || deq_cyc_q[1] - deq_cyc_q[0] != 1 + 3 * N_DST ||
            deq_idle_q[1] != deq_idle_q[0]) begin
            errors++;
            $display("FAIL b2b_gap: deqs=%0d gap=%0d idle_between=%0d required 2 %0d 0",
                     deq_cyc_q.size(), (deq_cyc_q.size() == 2) ? deq_cyc_q[1] - deq_cyc_q[0] : -1,
                     (deq_idle_q.size() == 2) ? deq_idle_q[1] - deq_idle_q[0] : -1, 1 + 3 * N_DST);
        end
    endtask

    task automatic test_write_stall();
        int n;
        int d1;
        logic [DATA_W-1:0] expd;
        clear_logs();
        for (int d = 0; d < N_DST; d++) wmem[4][d] = DATA_W'(d * 1000 + 5);
        set_inext(17'h00040);
        push_event(4'd4);
        expd = shadow[1];
        n = 0;
        while (!(bus.state === 3'd3 && bus.rd_dst === 2'd1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.state !== 3'd4 || bus.req_write_i_next !== 1'b1 || bus.dst_tag_out !== 2'd1 ||
                bus.i_next_out !== expd) begin
                errors++;
                $display("FAIL stall_hold%0d: state=%0d wr=%b dst=%0d data=%h required 4 1 1 %h",
                         i, bus.state, bus.req_write_i_next, bus.dst_tag_out, bus.i_next_out, expd);
            end
            if (i == 1) begin
                @(posedge clk);
                #2;
                bus.wr_stall = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.state !== 3'd2 || bus.rd_dst !== 2'd2) begin
            errors++;
            $display("FAIL stall_release: state=%0d rd_dst=%0d required 2 2", bus.state, bus.rd_dst);
        end
        wait_done("stall", 60);
        d1 = 0;
        foreach (wr_dst_q[i]) if (wr_dst_q[i] === 2'd1) d1++;
        checks++;
        if (d1 != 1 || wr_dst_q.size() != 4) begin
            errors++;
            $display("FAIL stall_accept: dst1 writes=%0d total=%0d required 1 4", d1, wr_dst_q.size());
        end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] exp_pos;
        logic [DATA_W-1:0] exp_neg;
`ifdef SPU_SAT_EN
        exp_pos = 17'h0FFFF;
        exp_neg = 17'h10000;
`else
        exp_pos = 17'h1E000;
        exp_neg = 17'h0F000;
`endif
        clear_logs();
        for (int d = 0; d < N_DST; d++) wmem[5][d] = 17'h0F000;
        set_inext(17'h0F000);
        push_event(4'd5);
        wait_done("sat_pos", 60);
        for (int i = 0; i < N_DST; i++) begin
            checks++;
            if (i >= wr_val_q.size() || wr_val_q[i] !== exp_pos) begin
                errors++;
                $display("FAIL sat_pos%0d: got %h required %h", i,
                         (i < wr_val_q.size()) ? wr_val_q[i] : 17'h00000, exp_pos);
            end
        end
`ifdef SPU_SAT_EN
        checks++;
        if (bus.sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag: got %b required 1", bus.sat_flag);
        end
`endif
        clear_logs();
        for (int d = 0; d < N_DST; d++) wmem[6][d] = 17'h10000;
        set_inext(17'h1F000);
        push_event(4'd6);
        wait_done("sat_neg", 60);
        checks++;
        if (wr_val_q.size() == 0 || wr_val_q[0] !== exp_neg) begin
            errors++;
            $display("FAIL sat_neg: got %h required %h",
                     (wr_val_q.size() > 0) ? wr_val_q[0] : 17'h00000, exp_neg);
        end
    endtask

    task automatic test_reset_mid_event();
        int n;
        int wc;
        clear_logs();
        for (int s = 7; s < 9; s++)
            for (int d = 0; d < N_DST; d++)
                wmem[s][d] = DATA_W'(s * 100 + d * 11);
        set_inext(17'h00010);
        push_event(4'd7);
        n = 0;
        while (!(bus.state === 3'd3 && bus.rd_dst === 2'd2) && n < 60) begin
            @(negedge clk);
            n++;
        end
        #1;
        asyn_reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        wc = wr_count;
        exp_q.delete();
        for (int d = 0; d < N_DST; d++) shadow[d] = inext_mem[d];
        repeat (2) @(negedge clk);
        asyn_reset = 1'b1;
        checks++;
        if (wr_count != wc || wr_dst_q.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_writes: before reset=%0d extra=%0d required 2 0",
                     wr_dst_q.size(), wr_count - wc);
        end
        clear_logs();
        push_event(4'd8);
        wait_done("after_reset", 60);
        checks++;
        if (wr_dst_q.size() != 4 || wr_dst_q[0] !== 2'd0 || wr_dst_q[3] !== 2'd3) begin
            errors++;
            $display("FAIL after_reset_dst: count=%0d first=%0d required 4 0", wr_dst_q.size(),
                     (wr_dst_q.size() > 0) ? wr_dst_q[0] : 2'd0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (excl_viol != 0) begin
            errors++;
            $display("FAIL strobe_exclusive: violations=%0d required 0", excl_viol);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; fall_cyc = 0; idle_seen = 0; excl_viol = 0; wr_count = 0;
        rd_pend = 1'b0; wr_pend = 1'b0; deq_pend = 1'b0; prev_empty = 1'b1;
        rd_src_p = '0; rd_dst_p = '0; wr_dst_p = '0; wr_data_p = '0;
        for (int s = 0; s < 16; s++)
            for (int d = 0; d < N_DST; d++) wmem[s][d] = 17'h00000;
        set_inext(17'h00000);
        asyn_reset     = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.src_tag_in = 4'd0;
        bus.weight_in  = 17'h00000;
        bus.i_next_in  = 17'h00000;
        bus.wr_stall   = 1'b0;

        fork
            // FIFO and memory responder: applies actions seen on the previous negedge.
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                if (deq_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
                deq_pend = 1'b0;
                if (wr_pend) inext_mem[wr_dst_p] = wr_data_p;
                wr_pend = 1'b0;
                if (rd_pend) begin
                    bus.weight_in = wmem[rd_src_p][rd_dst_p];
                    bus.i_next_in = inext_mem[rd_dst_p];
                end else begin
                    bus.weight_in = 17'h0AAAA;
                    bus.i_next_in = 17'h15555;
                end
                rd_pend = 1'b0;
                bus.fifo_empty = (fifo_q.size() == 0);
                bus.src_tag_in = (fifo_q.size() == 0) ? 4'd0 : fifo_q[0];
                if (prev_empty && !bus.fifo_empty) fall_cyc = cyc;
                prev_empty = bus.fifo_empty;
            end
            // Output monitor and write scoreboard.
            forever begin
                @(negedge clk);
                if (asyn_reset) begin
                    if ((32'(bus.req_deq) + 32'(bus.rd_req) + 32'(bus.req_write_i_next)) > 1) excl_viol++;
                    if (bus.req_deq && bus.state !== 3'd1) excl_viol++;
                    if (bus.rd_req && bus.state !== 3'd2) excl_viol++;
                    if (bus.req_write_i_next && bus.state !== 3'd4) excl_viol++;
                    if (bus.state === 3'd0) idle_seen++;
                    if (bus.req_deq) begin
                        deq_pend = 1'b1;
                        deq_cyc_q.push_back(cyc);
                        deq_idle_q.push_back(idle_seen);
                    end
                    if (bus.rd_req) begin
                        rd_pend  = 1'b1;
                        rd_src_p = bus.rd_src;
                        rd_dst_p = bus.rd_dst;
                    end
                    if (bus.req_write_i_next && !bus.wr_stall) begin
                        wr_t e;
                        wr_pend   = 1'b1;
                        wr_dst_p  = bus.dst_tag_out;
                        wr_data_p = bus.i_next_out;
                        wr_count++;
                        wr_cyc_q.push_back(cyc);
                        wr_val_q.push_back(bus.i_next_out);
                        wr_dst_q.push_back(bus.dst_tag_out);
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL wr_unexpected: dst=%0d data=%h required no write",
                                     bus.dst_tag_out, bus.i_next_out);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.dst_tag_out !== e.dst || bus.i_next_out !== e.data) begin
                                errors++;
                                $display("FAIL wr_data: dst=%0d data=%h required dst=%0d data=%h",
                                         bus.dst_tag_out, bus.i_next_out, e.dst, e.data);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single_event();
        test_back_to_back();
        test_write_stall();
        test_saturation();
        test_reset_mid_event();
        test_exclusive();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
